vram_arbiter: RTL

Shares the single read port of the text-mode VRAM between the display fetch pipeline and the CPU MMIO bus, and sequences CPU writes, including read-modify-write for partial-word strobes, onto the write port. Sits in the VGA core between the video timing/fetch logic and the 16-bit 1R1W VRAM, entirely in the pixel clock domain. Display fetches always win and see zero added latency; CPU accesses absorb any conflict.

---
 rtl/vram_arbiter_pkg.sv | 30 +++
 rtl/vram_arbiter_if.sv | 22 ++
 rtl/vram_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: default geometry, CPU FSM states
// and the byte-merge used by partial-word CPU writes.
package vram_arbiter_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RMW_REQ,
        RMW_WAIT,
        WR,
        RESP
    } cpuState_e;

    // Overlay the strobed bytes of newData onto oldData; unstrobed bytes keep the stored value.
    function automatic logic [DW_DEF-1:0] mergeBytes(
        input logic [1:0]        strb,
        input logic [DW_DEF-1:0] newData,
        input logic [DW_DEF-1:0] oldData
    );
        logic [DW_DEF-1:0] merged;
        merged[7:0]  = strb[0] ? newData[7:0]  : oldData[7:0];
        merged[15:8] = strb[1] ? newData[15:8] : oldData[15:8];
        return merged;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU MMIO bus as seen by the VRAM arbiter. The CPU side is the master; the
// arbiter is the slave and answers with a one-cycle ready pulse.
interface vram_arbiter_if;

    logic        sel;
    logic [3:0]  wstrb;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output sel, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  sel, wstrb, addr, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares the single VRAM read port between the display fetch
// path (always wins, zero added latency) and CPU MMIO accesses, and sequences
// CPU writes onto the write port, using read-modify-write for byte strobes.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,

    vram_arbiter_if.slave cpu,

    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic          disp_valid_o,
    output logic [DW-1:0] disp_data_o,

    output logic          ram_ren_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [DW-1:0] ram_rdata_i,

    output logic          ram_wen_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_wdata_o,

    output logic [15:0]   stall_cnt_o
);

    cpuState_e     state_q;
    logic [AW-1:0] wordAddr_q;
    logic [1:0]    strb_q;
    logic [DW-1:0] writeBuf_q;
    logic [DW-1:0] readData_q;
    logic          ready_q;
    logic          ramWen_q;
    logic          lastDisp_q;
    logic [15:0]   stallCnt_q;
    logic [15:0]   stallCnt_d;

    // Bus bits outside the VRAM word are ignored by this block.
    logic unusedBits;
    assign unusedBits = ^{cpu.addr[23:AW+2], cpu.addr[1:0], cpu.wdata[31:DW]};

    // Saturating next value for the display-blocked CPU read counter.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stallCnt_q != 16'hFFFF) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    // Read-port mux: display wins outright; the CPU only reads from its request states, never during reset.
    always_comb begin
        ram_ren_o   = 1'b0;
        ram_raddr_o = wordAddr_q;
        if (disp_req_i) begin
            ram_ren_o   = 1'b1;
            ram_raddr_o = disp_addr_i;
        end else if (!reset && (state_q == RD_REQ || state_q == RMW_REQ)) begin
            ram_ren_o = 1'b1;
        end
    end

    // Remember that the read issued this cycle belonged to the display, so its data is flagged next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastDisp_q <= 1'b0;
        end else begin
            lastDisp_q <= disp_req_i;
        end
    end

    // CPU transaction FSM with registered ready and write-enable pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wordAddr_q <= '0;
            strb_q     <= '0;
            writeBuf_q <= '0;
            readData_q <= '0;
            ready_q    <= 1'b0;
            ramWen_q   <= 1'b0;
            stallCnt_q <= '0;
        end else begin
            ready_q  <= 1'b0;
            ramWen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu.sel) begin
                        wordAddr_q <= cpu.addr[AW+1:2];
                        strb_q     <= cpu.wstrb[1:0];
                        writeBuf_q <= cpu.wdata[DW-1:0];
                        if (cpu.wstrb == 4'b0000) begin
                            state_q <= RD_REQ;
                        end else if (cpu.wstrb[1:0] == 2'b11) begin
                            state_q  <= WR;
                            ramWen_q <= 1'b1;
                        end else if (cpu.wstrb[1:0] == 2'b00) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= RMW_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (disp_req_i) begin
                        stallCnt_q <= stallCnt_d;
                    end else begin
                        state_q <= RD_WAIT;
                    end
                end
                RMW_REQ: begin
                    if (disp_req_i) begin
                        stallCnt_q <= stallCnt_d;
                    end else begin
                        state_q <= RMW_WAIT;
                    end
                end
                RD_WAIT: begin
                    readData_q <= ram_rdata_i;
                    state_q    <= RESP;
                    ready_q    <= 1'b1;
                end
                RMW_WAIT: begin
                    writeBuf_q <= mergeBytes(strb_q, writeBuf_q, ram_rdata_i);
                    state_q    <= WR;
                    ramWen_q   <= 1'b1;
                end
                WR: begin
                    state_q <= RESP;
                    ready_q <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign disp_valid_o = lastDisp_q;
    assign disp_data_o  = ram_rdata_i;

    assign ram_wen_o    = ramWen_q;
    assign ram_waddr_o  = wordAddr_q;
    assign ram_wdata_o  = writeBuf_q;

    assign cpu.ready    = ready_q;
    assign cpu.rdata    = {{(32-DW){1'b0}}, readData_q};
    assign stall_cnt_o  = stallCnt_q;

endmodule
